// File: rtl/axil_reg_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module  : axil_reg_bank_pkg
// Brief   : Shared response codes, FSM state types and byte-merge helper for
//           the AXI4-Lite register bank.
// Rev     : 1.0 - initial release
// ============================================================================
package axil_reg_bank_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [0:0] {
      WR_IDLE = 1'b0,
      WR_RESP = 1'b1
   } wr_state_t;

   typedef enum logic [0:0] {
      RD_IDLE = 1'b0,
      RD_DATA = 1'b1
   } rd_state_t;

   // Sized for the widest supported bus; callers zero-extend and truncate.
   function automatic logic [63:0] byte_merge(
      input logic [63:0] old_val,
      input logic [63:0] new_val,
      input logic [7:0]  strb
   );
      logic [63:0] merged;
      for (int b = 0; b < 8; b++) begin
         merged[b*8 +: 8] = strb[b] ? new_val[b*8 +: 8] : old_val[b*8 +: 8];
      end
      return merged;
   endfunction

endpackage
`default_nettype wire

// File: rtl/axil_addr_decode.sv
`default_nettype none
// ============================================================================
// Module  : axil_addr_decode
// Brief   : Byte address to register index, with in-range and read-only flags.
// Rev     : 1.0 - initial release
// ============================================================================
module axil_addr_decode #(
   parameter int ADDR_W   = 8,
   parameter int OFFS_W   = 2,
   parameter int NUM_REGS = 8,
   parameter int NUM_RO   = 2
) (
   input  logic [ADDR_W-1:0]        i_addr,
   output logic [ADDR_W-OFFS_W-1:0] o_idx,
   output logic                     o_in_range,
   output logic                     o_is_ro
);

   logic [31:0] w_idx_ext;
   logic        w_unused_offs;

   assign o_idx      = i_addr[ADDR_W-1:OFFS_W];
   assign w_idx_ext  = 32'(o_idx);
   assign o_in_range = (w_idx_ext < 32'(NUM_REGS));
   assign o_is_ro    = o_in_range && (w_idx_ext >= 32'(NUM_REGS - NUM_RO));

   // Sub-word offset bits are dropped: unaligned accesses act as aligned.
   assign w_unused_offs = ^i_addr[OFFS_W-1:0];

endmodule
`default_nettype wire

// File: rtl/axil_reg_bank.sv
`default_nettype none
// ============================================================================
// Module  : axil_reg_bank
// Brief   : Parametrised AXI4-Lite register bank, R/W control words at low
//           indices, read-only status words at the top indices.
//           Optional macro AXIL_REG_BANK_WR_PULSE_EN adds wr_pulse_o doorbells.
// Rev     : 1.0 - initial release
// ============================================================================
module axil_reg_bank
   import axil_reg_bank_pkg::*;
#(
   parameter int                DATA_W   = 32,
   parameter int                ADDR_W   = 8,
   parameter int                NUM_REGS = 8,
   parameter int                NUM_RO   = 2,
   parameter logic [DATA_W-1:0] RST_VAL  = '0
) (
   input  logic                                ACLK,
   input  logic                                ARESET,
   input  logic [ADDR_W-1:0]                   S_AXI_AWADDR,
   input  logic [2:0]                          S_AXI_AWPROT,
   input  logic                                S_AXI_AWVALID,
   output logic                                S_AXI_AWREADY,
   input  logic [DATA_W-1:0]                   S_AXI_WDATA,
   input  logic [DATA_W/8-1:0]                 S_AXI_WSTRB,
   input  logic                                S_AXI_WVALID,
   output logic                                S_AXI_WREADY,
   output logic [1:0]                          S_AXI_BRESP,
   output logic                                S_AXI_BVALID,
   input  logic                                S_AXI_BREADY,
   input  logic [ADDR_W-1:0]                   S_AXI_ARADDR,
   input  logic [2:0]                          S_AXI_ARPROT,
   input  logic                                S_AXI_ARVALID,
   output logic                                S_AXI_ARREADY,
   output logic [DATA_W-1:0]                   S_AXI_RDATA,
   output logic [1:0]                          S_AXI_RRESP,
   output logic                                S_AXI_RVALID,
   input  logic                                S_AXI_RREADY,
   output logic [(NUM_REGS-NUM_RO)*DATA_W-1:0] ctrl_o,
`ifdef AXIL_REG_BANK_WR_PULSE_EN
   output logic [NUM_REGS-NUM_RO-1:0]          wr_pulse_o,
`endif
   input  logic [NUM_RO*DATA_W-1:0]            status_i
);

   localparam int NUM_RW = NUM_REGS - NUM_RO;
   localparam int STRB_W = DATA_W / 8;
   localparam int OFFS_W = $clog2(STRB_W);
   localparam int IDX_W  = ADDR_W - OFFS_W;

   wr_state_t          r_wr_state;
   wr_state_t          w_wr_next;
   rd_state_t          r_rd_state;
   rd_state_t          w_rd_next;

   logic               r_aw_held;
   logic               r_w_held;
   logic [ADDR_W-1:0]  r_awaddr;
   logic [DATA_W-1:0]  r_wdata;
   logic [STRB_W-1:0]  r_wstrb;
   logic [1:0]         r_bresp;
   logic [DATA_W-1:0]  r_rdata;
   logic [1:0]         r_rresp;

   logic               w_aw_fire;
   logic               w_w_fire;
   logic               w_ar_fire;
   logic               w_wr_commit;
   logic               w_wr_ok;
   logic [1:0]         w_wr_resp;
   logic [1:0]         w_rd_resp;
   logic [DATA_W-1:0]  w_rd_word;

   logic [IDX_W-1:0]   w_wr_idx;
   logic               w_wr_in_range;
   logic               w_wr_is_ro;
   logic [IDX_W-1:0]   w_rd_idx;
   logic               w_rd_in_range;
   logic               w_unused_rd_ro;
   logic               w_unused_prot;

   axil_addr_decode #(
      .ADDR_W   (ADDR_W),
      .OFFS_W   (OFFS_W),
      .NUM_REGS (NUM_REGS),
      .NUM_RO   (NUM_RO)
   ) u_wr_dec (
      .i_addr     (r_awaddr),
      .o_idx      (w_wr_idx),
      .o_in_range (w_wr_in_range),
      .o_is_ro    (w_wr_is_ro)
   );

   axil_addr_decode #(
      .ADDR_W   (ADDR_W),
      .OFFS_W   (OFFS_W),
      .NUM_REGS (NUM_REGS),
      .NUM_RO   (NUM_RO)
   ) u_rd_dec (
      .i_addr     (S_AXI_ARADDR),
      .o_idx      (w_rd_idx),
      .o_in_range (w_rd_in_range),
      .o_is_ro    (w_unused_rd_ro)
   );

   assign w_unused_prot = ^{S_AXI_AWPROT, S_AXI_ARPROT, w_unused_rd_ro};

   assign w_aw_fire = S_AXI_AWVALID && S_AXI_AWREADY;
   assign w_w_fire  = S_AXI_WVALID  && S_AXI_WREADY;
   assign w_ar_fire = S_AXI_ARVALID && S_AXI_ARREADY;
   assign w_wr_ok   = w_wr_in_range && !w_wr_is_ro;

   always_comb begin
      w_wr_resp = RESP_OKAY;
      if (!w_wr_in_range) begin
         w_wr_resp = RESP_DECERR;
      end else if (w_wr_is_ro) begin
         w_wr_resp = RESP_SLVERR;
      end
   end

   assign w_rd_resp = w_rd_in_range ? RESP_OKAY : RESP_DECERR;

   // ---------------------------------------------------------------- write
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         r_wr_state <= WR_IDLE;
      end else begin
         r_wr_state <= w_wr_next;
      end
   end

   always_comb begin
      w_wr_next     = r_wr_state;
      w_wr_commit   = 1'b0;
      S_AXI_AWREADY = 1'b0;
      S_AXI_WREADY  = 1'b0;
      S_AXI_BVALID  = 1'b0;
      case (r_wr_state)
         WR_IDLE: begin
            S_AXI_AWREADY = !r_aw_held;
            S_AXI_WREADY  = !r_w_held;
            if (r_aw_held && r_w_held) begin
               w_wr_commit = 1'b1;
               w_wr_next   = WR_RESP;
            end
         end
         WR_RESP: begin
            S_AXI_BVALID = 1'b1;
            if (S_AXI_BREADY) begin
               w_wr_next = WR_IDLE;
            end
         end
         default: w_wr_next = WR_IDLE;
      endcase
   end

   // AW and W are captured independently; the commit consumes both at once.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         r_aw_held <= 1'b0;
         r_w_held  <= 1'b0;
         r_awaddr  <= '0;
         r_wdata   <= '0;
         r_wstrb   <= '0;
         r_bresp   <= RESP_OKAY;
      end else if (w_wr_commit) begin
         r_aw_held <= 1'b0;
         r_w_held  <= 1'b0;
         r_bresp   <= w_wr_resp;
      end else begin
         if (w_aw_fire) begin
            r_aw_held <= 1'b1;
            r_awaddr  <= S_AXI_AWADDR;
         end
         if (w_w_fire) begin
            r_w_held <= 1'b1;
            r_wdata  <= S_AXI_WDATA;
            r_wstrb  <= S_AXI_WSTRB;
         end
      end
   end

   assign S_AXI_BRESP = r_bresp;

   generate
      for (genvar k = 0; k < NUM_RW; k++) begin : g_rw
         logic [DATA_W-1:0] r_reg;
         always_ff @(posedge ACLK or posedge ARESET) begin
            if (ARESET) begin
               r_reg <= RST_VAL;
            end else if (w_wr_commit && w_wr_ok && (w_wr_idx == IDX_W'(k))) begin
               r_reg <= DATA_W'(byte_merge(64'(r_reg), 64'(r_wdata), 8'(r_wstrb)));
            end
         end
         assign ctrl_o[k*DATA_W +: DATA_W] = r_reg;
      end
   endgenerate

`ifdef AXIL_REG_BANK_WR_PULSE_EN
   logic [NUM_RW-1:0] r_wr_pulse;

   // Fires on every accepted write, even one with no strobes set.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         r_wr_pulse <= '0;
      end else begin
         for (int k = 0; k < NUM_RW; k++) begin
            r_wr_pulse[k] <= w_wr_commit && w_wr_ok && (w_wr_idx == IDX_W'(k));
         end
      end
   end

   assign wr_pulse_o = r_wr_pulse;
`endif

   // ----------------------------------------------------------------- read
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         r_rd_state <= RD_IDLE;
      end else begin
         r_rd_state <= w_rd_next;
      end
   end

   always_comb begin
      w_rd_next     = r_rd_state;
      S_AXI_ARREADY = 1'b0;
      S_AXI_RVALID  = 1'b0;
      case (r_rd_state)
         RD_IDLE: begin
            S_AXI_ARREADY = 1'b1;
            if (S_AXI_ARVALID) begin
               w_rd_next = RD_DATA;
            end
         end
         RD_DATA: begin
            S_AXI_RVALID = 1'b1;
            if (S_AXI_RREADY) begin
               w_rd_next = RD_IDLE;
            end
         end
         default: w_rd_next = RD_IDLE;
      endcase
   end

   // Out-of-range indices match nothing and read as zero.
   always_comb begin
      w_rd_word = '0;
      for (int k = 0; k < NUM_RW; k++) begin
         if (w_rd_idx == IDX_W'(k)) begin
            w_rd_word = ctrl_o[k*DATA_W +: DATA_W];
         end
      end
      for (int j = 0; j < NUM_RO; j++) begin
         if (w_rd_idx == IDX_W'(NUM_RW + j)) begin
            w_rd_word = status_i[j*DATA_W +: DATA_W];
         end
      end
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         r_rdata <= '0;
         r_rresp <= RESP_OKAY;
      end else if (w_ar_fire) begin
         r_rdata <= w_rd_word;
         r_rresp <= w_rd_resp;
      end
   end

   assign S_AXI_RDATA = r_rdata;
   assign S_AXI_RRESP = r_rresp;

endmodule
`default_nettype wire

// File: tb/tb_axil_reg_bank.sv
`default_nettype none
// ============================================================================
// Module  : tb_axil_reg_bank
// Brief   : Self-checking bench for axil_reg_bank against an array-based model.
// Rev     : 1.0 - initial release
// ============================================================================
module tb_axil_reg_bank;

   localparam int NUM_REGS = 8;
   localparam int NUM_RO   = 2;
   localparam int NUM_RW   = NUM_REGS - NUM_RO;

   logic        ACLK = 1'b0;
   logic        ARESET = 1'b0;
   logic [7:0]  S_AXI_AWADDR = '0;
   logic [2:0]  S_AXI_AWPROT = '0;
   logic        S_AXI_AWVALID = 1'b0;
   logic        S_AXI_AWREADY;
   logic [31:0] S_AXI_WDATA = '0;
   logic [3:0]  S_AXI_WSTRB = '0;
   logic        S_AXI_WVALID = 1'b0;
   logic        S_AXI_WREADY;
   logic [1:0]  S_AXI_BRESP;
   logic        S_AXI_BVALID;
   logic        S_AXI_BREADY = 1'b0;
   logic [7:0]  S_AXI_ARADDR = '0;
   logic [2:0]  S_AXI_ARPROT = '0;
   logic        S_AXI_ARVALID = 1'b0;
   logic        S_AXI_ARREADY;
   logic [31:0] S_AXI_RDATA;
   logic [1:0]  S_AXI_RRESP;
   logic        S_AXI_RVALID;
   logic        S_AXI_RREADY = 1'b0;
   logic [NUM_RW*32-1:0] ctrl_o;
   logic [NUM_RO*32-1:0] status_i;
`ifdef AXIL_REG_BANK_WR_PULSE_EN
   logic [NUM_RW-1:0] wr_pulse_o;
`endif

   logic [31:0] mdl  [NUM_RW];
   logic [31:0] stat [NUM_RO];
   int total = 0;
   int bad   = 0;

   assign status_i = {stat[1], stat[0]};

   axil_reg_bank dut (
      .ACLK          (ACLK),
      .ARESET        (ARESET),
      .S_AXI_AWADDR  (S_AXI_AWADDR),
      .S_AXI_AWPROT  (S_AXI_AWPROT),
      .S_AXI_AWVALID (S_AXI_AWVALID),
      .S_AXI_AWREADY (S_AXI_AWREADY),
      .S_AXI_WDATA   (S_AXI_WDATA),
      .S_AXI_WSTRB   (S_AXI_WSTRB),
      .S_AXI_WVALID  (S_AXI_WVALID),
      .S_AXI_WREADY  (S_AXI_WREADY),
      .S_AXI_BRESP   (S_AXI_BRESP),
      .S_AXI_BVALID  (S_AXI_BVALID),
      .S_AXI_BREADY  (S_AXI_BREADY),
      .S_AXI_ARADDR  (S_AXI_ARADDR),
      .S_AXI_ARPROT  (S_AXI_ARPROT),
      .S_AXI_ARVALID (S_AXI_ARVALID),
      .S_AXI_ARREADY (S_AXI_ARREADY),
      .S_AXI_RDATA   (S_AXI_RDATA),
      .S_AXI_RRESP   (S_AXI_RRESP),
      .S_AXI_RVALID  (S_AXI_RVALID),
      .S_AXI_RREADY  (S_AXI_RREADY),
      .ctrl_o        (ctrl_o),
`ifdef AXIL_REG_BANK_WR_PULSE_EN
      .wr_pulse_o    (wr_pulse_o),
`endif
      .status_i      (status_i)
   );

   always #5 ACLK = ~ACLK;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // ---------------------------------------------------------------- model
   function automatic logic [1:0] exp_resp(input int idx, input bit is_wr);
      if (idx >= NUM_REGS) return 2'b11;
      if (is_wr && idx >= NUM_RW) return 2'b10;
      return 2'b00;
   endfunction

   function automatic logic [31:0] exp_read(input int idx);
      if (idx >= NUM_REGS) return 32'h0;
      if (idx >= NUM_RW) return stat[idx-NUM_RW];
      return mdl[idx];
   endfunction

   task automatic mdl_write(input int idx, input logic [31:0] d, input logic [3:0] s);
      if (exp_resp(idx, 1'b1) != 2'b00) return;
      for (int b = 0; b < 4; b++) begin
         if (s[b]) mdl[idx][b*8 +: 8] = d[b*8 +: 8];
      end
   endtask

   task automatic chk_ctrl(input string tag);
      for (int k = 0; k < NUM_RW; k++) begin
         chk($sformatf("%s_ctrl%0d", tag, k), 64'(ctrl_o[k*32 +: 32]), 64'(mdl[k]));
      end
   endtask

   // ------------------------------------------------------------ drivers
   // Called #1 after a rising edge; returns #1 after a rising edge.
   task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int b_dly,
                            output logic [1:0] resp, output int lat, output bit stall_ok,
                            output int pcnt, output logic [NUM_RW-1:0] pval);
      bit aw_done = 0, w_done = 0, b_done = 0;
      int cyc = 0, hs = -1, bv_first = -1, bv_n = 0;
      logic [1:0] bresp0 = '0;
      resp = 'x; lat = -1; stall_ok = 1; pcnt = 0; pval = '0;
      while (!b_done && cyc < 100) begin
         S_AXI_AWADDR  = addr;
         S_AXI_WDATA   = data;
         S_AXI_WSTRB   = strb;
         S_AXI_AWVALID = !aw_done && (cyc >= aw_dly);
         S_AXI_WVALID  = !w_done && (cyc >= w_dly);
         S_AXI_BREADY  = (bv_n >= b_dly);
         @(negedge ACLK);
         if (aw_done && S_AXI_AWREADY) stall_ok = 0;
         if (w_done && S_AXI_WREADY) stall_ok = 0;
         if (S_AXI_AWVALID && S_AXI_AWREADY) begin aw_done = 1; hs = cyc; end
         if (S_AXI_WVALID && S_AXI_WREADY) begin w_done = 1; hs = cyc; end
`ifdef AXIL_REG_BANK_WR_PULSE_EN
         if (wr_pulse_o != '0) begin pcnt++; pval |= wr_pulse_o; end
`endif
         if (S_AXI_BVALID) begin
            if (bv_n == 0) begin
               bv_first = cyc;
               bresp0   = S_AXI_BRESP;
            end else if (S_AXI_BRESP !== bresp0) begin
               stall_ok = 0;
            end
            bv_n++;
            if (S_AXI_BREADY) begin b_done = 1; resp = S_AXI_BRESP; end
         end
         @(posedge ACLK); #1;
         cyc++;
      end
      S_AXI_AWVALID = 1'b0;
      S_AXI_WVALID  = 1'b0;
      S_AXI_BREADY  = 1'b0;
      if (bv_first >= 0 && hs >= 0) lat = bv_first - hs;
      chk("wr_done", 64'(b_done), 64'd1);
   endtask

   task automatic axi_read(input logic [7:0] addr, input int r_dly,
                           output logic [31:0] data, output logic [1:0] resp,
                           output int lat, output bit stable_ok);
      bit ar_done = 0, r_done = 0;
      int cyc = 0, hs = -1, rv_first = -1, rv_n = 0;
      logic [33:0] snap = '0;
      data = 'x; resp = 'x; lat = -1; stable_ok = 1;
      while (!r_done && cyc < 100) begin
         S_AXI_ARADDR  = addr;
         S_AXI_ARVALID = !ar_done;
         S_AXI_RREADY  = (rv_n >= r_dly);
         @(negedge ACLK);
         if (ar_done && S_AXI_ARREADY) stable_ok = 0;
         if (S_AXI_ARVALID && S_AXI_ARREADY) begin ar_done = 1; hs = cyc; end
         if (S_AXI_RVALID) begin
            if (rv_n == 0) begin
               rv_first = cyc;
               snap     = {S_AXI_RRESP, S_AXI_RDATA};
            end else if ({S_AXI_RRESP, S_AXI_RDATA} !== snap) begin
               stable_ok = 0;
            end
            rv_n++;
            if (S_AXI_RREADY) begin r_done = 1; data = S_AXI_RDATA; resp = S_AXI_RRESP; end
         end
         @(posedge ACLK); #1;
         cyc++;
      end
      S_AXI_ARVALID = 1'b0;
      S_AXI_RREADY  = 1'b0;
      if (rv_first >= 0 && hs >= 0) lat = rv_first - hs;
      chk("rd_done", 64'(r_done), 64'd1);
   endtask

   // ------------------------------------------------------------ sequence
   initial begin
      logic [1:0]        resp;
      logic [31:0]       rd;
      logic [31:0]       wd;
      logic [3:0]        ws;
      logic [NUM_RW-1:0] pv;
      logic [NUM_RW-1:0] pexp;
      int                lat;
      int                pc;
      int                idx;
      int                ridx;
      bit                ok;

      for (int k = 0; k < NUM_RW; k++) mdl[k] = 32'h0;
      stat[0] = $urandom;
      stat[1] = $urandom;

      #2 ARESET = 1'b1;
      repeat (3) @(posedge ACLK);
      #1 ARESET = 1'b0;

      // reset state
      chk("rst_awready", 64'(S_AXI_AWREADY), 64'd1);
      chk("rst_wready",  64'(S_AXI_WREADY),  64'd1);
      chk("rst_arready", 64'(S_AXI_ARREADY), 64'd1);
      chk("rst_bvalid",  64'(S_AXI_BVALID),  64'd0);
      chk("rst_rvalid",  64'(S_AXI_RVALID),  64'd0);
      chk("rst_bresp",   64'(S_AXI_BRESP),   64'd0);
      chk("rst_rresp",   64'(S_AXI_RRESP),   64'd0);
      chk("rst_rdata",   64'(S_AXI_RDATA),   64'd0);
      chk_ctrl("rst");

      // basic writes and read-back; AW+W together -> BVALID one edge after commit edge
      for (int i = 0; i < 4; i++) begin
         axi_write(8'(i*4), 32'(i+1), 4'hF, 0, 0, 0, resp, lat, ok, pc, pv);
         mdl_write(i, 32'(i+1), 4'hF);
         chk($sformatf("basic_bresp%0d", i), 64'(resp), 64'(exp_resp(i, 1'b1)));
         if (i == 0) chk("b_latency", 64'(lat), 64'd2);
      end
      for (int i = 0; i < 4; i++) begin
         axi_read(8'(i*4), 0, rd, resp, lat, ok);
         chk($sformatf("basic_rdata%0d", i), 64'(rd), 64'(i+1));
         chk($sformatf("basic_rresp%0d", i), 64'(resp), 64'd0);
         if (i == 0) chk("r_latency", 64'(lat), 64'd1);
      end
      chk("basic_ctrl0", 64'(ctrl_o[31:0]), 64'h1);

      // byte strobes
      axi_write(8'h00, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, resp, lat, ok, pc, pv);
      mdl_write(0, 32'hFFFF_FFFF, 4'hF);
      axi_write(8'h00, 32'h1234_5678, 4'b0101, 0, 0, 0, resp, lat, ok, pc, pv);
      mdl_write(0, 32'h1234_5678, 4'b0101);
      axi_read(8'h00, 0, rd, resp, lat, ok);
      chk("strb_rdata", 64'(rd), 64'hFF34_FF78);
      chk("strb_model", 64'(rd), 64'(mdl[0]));

      // W three cycles ahead of AW, B held off for five cycles
      wd = $urandom;
      axi_write(8'h04, wd, 4'hF, 3, 0, 5, resp, lat, ok, pc, pv);
      mdl_write(1, wd, 4'hF);
      chk("stall_bresp", 64'(resp), 64'd0);
      chk("stall_hold", 64'(ok), 64'd1);
      chk("stall_bvalid_drop", 64'(S_AXI_BVALID), 64'd0);
      axi_read(8'h04, 0, rd, resp, lat, ok);
      chk("stall_rdata", 64'(rd), 64'(wd));

      // read-only and out-of-range indices
      axi_write(8'h18, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, resp, lat, ok, pc, pv);
      chk("ro_bresp", 64'(resp), 64'h2);
      chk_ctrl("ro");
      stat[0] = 32'h0000_CAFE;
      axi_read(8'h18, 0, rd, resp, lat, ok);
      chk("status_rdata", 64'(rd), 64'hCAFE);
      chk("status_rresp", 64'(resp), 64'd0);
      axi_read(8'h40, 2, rd, resp, lat, ok);
      chk("oor_rdata", 64'(rd), 64'd0);
      chk("oor_rresp", 64'(resp), 64'h3);
      chk("oor_stable", 64'(ok), 64'd1);
      axi_write(8'h40, 32'h5555_5555, 4'hF, 0, 0, 0, resp, lat, ok, pc, pv);
      chk("oor_bresp", 64'(resp), 64'h3);
      chk_ctrl("oor");

      // read captured on the same edge as the write commit sees the old value
      S_AXI_AWADDR = 8'h08; S_AXI_WDATA = 32'hA1B2_C3D4; S_AXI_WSTRB = 4'hF;
      S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
      @(posedge ACLK); #1;
      S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
      S_AXI_ARADDR = 8'h08; S_AXI_ARVALID = 1'b1;
      @(posedge ACLK); #1;
      S_AXI_ARVALID = 1'b0;
      chk("rw_same_rvalid", 64'(S_AXI_RVALID), 64'd1);
      chk("rw_same_bvalid", 64'(S_AXI_BVALID), 64'd1);
      chk("rw_same_rdata", 64'(S_AXI_RDATA), 64'(mdl[2]));
      S_AXI_RREADY = 1'b1; S_AXI_BREADY = 1'b1;
      @(posedge ACLK); #1;
      S_AXI_RREADY = 1'b0; S_AXI_BREADY = 1'b0;
      mdl_write(2, 32'hA1B2_C3D4, 4'hF);
      chk_ctrl("rw_same");

      // randomized traffic, including unaligned and out-of-range addresses
      for (int it = 0; it < 24; it++) begin
         idx = $urandom_range(0, 9);
         wd  = $urandom;
         ws  = 4'($urandom_range(0, 15));
         axi_write(8'(idx*4 + $urandom_range(0, 3)), wd, ws,
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                   resp, lat, ok, pc, pv);
         chk($sformatf("rnd%0d_bresp", it), 64'(resp), 64'(exp_resp(idx, 1'b1)));
         chk($sformatf("rnd%0d_whold", it), 64'(ok), 64'd1);
         mdl_write(idx, wd, ws);
         chk_ctrl($sformatf("rnd%0d", it));
`ifdef AXIL_REG_BANK_WR_PULSE_EN
         pexp = '0;
         if (idx < NUM_RW) pexp[idx] = 1'b1;
         chk($sformatf("rnd%0d_pulse", it), 64'(pv), 64'(pexp));
         chk($sformatf("rnd%0d_pcnt", it), 64'(pc), 64'(idx < NUM_RW ? 1 : 0));
`endif
         stat[0] = $urandom;
         stat[1] = $urandom;
         ridx = $urandom_range(0, 9);
         axi_read(8'(ridx*4 + $urandom_range(0, 3)), $urandom_range(0, 3), rd, resp, lat, ok);
         chk($sformatf("rnd%0d_rdata", it), 64'(rd), 64'(exp_read(ridx)));
         chk($sformatf("rnd%0d_rresp", it), 64'(resp), 64'(exp_resp(ridx, 1'b0)));
         chk($sformatf("rnd%0d_rhold", it), 64'(ok), 64'd1);
      end

      // reset while both a B and an R response are pending
      S_AXI_AWADDR = 8'h00; S_AXI_WDATA = 32'hA5A5_0001; S_AXI_WSTRB = 4'hF;
      S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
      S_AXI_ARADDR = 8'h04; S_AXI_ARVALID = 1'b1;
      @(posedge ACLK); #1;
      S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
      @(posedge ACLK); #1;
      mdl_write(0, 32'hA5A5_0001, 4'hF);
      chk("prerst_bvalid", 64'(S_AXI_BVALID), 64'd1);
      chk("prerst_rvalid", 64'(S_AXI_RVALID), 64'd1);
      chk("prerst_ctrl0", 64'(ctrl_o[31:0]), 64'(mdl[0]));
      #2 ARESET = 1'b1;
      #1;
      chk("midrst_bvalid", 64'(S_AXI_BVALID), 64'd0);
      chk("midrst_rvalid", 64'(S_AXI_RVALID), 64'd0);
      chk("midrst_awready", 64'(S_AXI_AWREADY), 64'd1);
      chk("midrst_arready", 64'(S_AXI_ARREADY), 64'd1);
      for (int k = 0; k < NUM_RW; k++) mdl[k] = 32'h0;
      chk_ctrl("midrst");
      @(posedge ACLK); #1;
      ARESET = 1'b0;
      @(posedge ACLK); #1;
      wd = $urandom;
      axi_write(8'h14, wd, 4'hF, 1, 0, 1, resp, lat, ok, pc, pv);
      mdl_write(5, wd, 4'hF);
      chk("postrst_bresp", 64'(resp), 64'd0);
      axi_read(8'h14, 1, rd, resp, lat, ok);
      chk("postrst_rdata", 64'(rd), 64'(wd));
      chk("postrst_rresp", 64'(resp), 64'd0);
      chk_ctrl("postrst");

`ifdef AXIL_REG_BANK_WR_PULSE_EN
      // doorbells: one-cycle pulse on an OKAY write, including empty strobes
      axi_write(8'h08, 32'h0, 4'h0, 0, 0, 2, resp, lat, ok, pc, pv);
      chk("pulse_reg2_val", 64'(pv), 64'b000100);
      chk("pulse_reg2_cnt", 64'(pc), 64'd1);
      chk("pulse_reg2_unchanged", 64'(ctrl_o[2*32 +: 32]), 64'(mdl[2]));
      axi_write(8'h18, 32'h1, 4'hF, 0, 0, 0, resp, lat, ok, pc, pv);
      chk("pulse_ro_cnt", 64'(pc), 64'd0);
      chk("pulse_idle", 64'(wr_pulse_o), 64'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
